// File: rtl/pipelined_if_fetch.sv
// Instruction-fetch stage feeding the IF/ID register: owns the PC, talks to a
// variable-latency instruction memory and applies ID redirects.
module pipelined_if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        wpcir,
    input  logic [1:0]  Pcsource,
    input  logic [31:0] Bpc,
    input  logic [31:0] Rpc,
    input  logic [31:0] Jpc,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    input  logic        Imem_Ack,
    input  logic [31:0] Imem_Data,
    output logic [31:0] PC_plus4,
    output logic [31:0] IF_Inst,
    output logic        IF_Valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pend_pc;
    logic [31:0] inst_buf;

    logic [31:0] target;
    logic [31:0] seq_pc;
    logic        redirect;
    logic        ack;

    always_comb begin
        // NOTE: default assignment first, so every path assigns target and no latch is inferred.
        target = Bpc;
        case (Pcsource)
            2'b10:   target = Rpc;
            2'b11:   target = Jpc;
            default: target = Bpc;
        endcase
    end

    assign seq_pc   = pc + 32'd4;
    assign redirect = wpcir && (Pcsource != 2'b00);
    assign ack      = Imem_Req && Imem_Ack;

    // Reset gates the request and valid immediately, independent of the clock.
    assign Imem_Req  = !Clr && (state != HOLD);
    assign Imem_Addr = pc;
    assign PC_plus4  = seq_pc;
    assign IF_Inst   = (state == HOLD) ? inst_buf : Imem_Data;
    assign IF_Valid  = !Clr && ((state == HOLD) || ((state == FETCH) && Imem_Ack));

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            pend_pc  <= 32'd0;
            inst_buf <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (ack) begin
                        if (wpcir) begin
                            pc <= redirect ? target : seq_pc;
                        end else begin
                            inst_buf <= Imem_Data;
                            state    <= HOLD;
                        end
                    end else if (redirect) begin
                        pend_pc <= target;
                        state   <= DROP;
                    end
                end
                HOLD: begin
                    if (wpcir) begin
                        pc    <= redirect ? target : seq_pc;
                        state <= FETCH;
                    end
                end
                DROP: begin
                    // The wrong-path request must complete before the target can be issued.
                    if (ack) begin
                        pc    <= redirect ? target : pend_pc;
                        state <= FETCH;
                    end else if (redirect) begin
                        pend_pc <= target;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_pipelined_if_fetch.sv
// Bench for pipelined_if_fetch: directed scenarios plus a randomized run checked
// against a program-order model of the instruction stream IF/ID should capture.
module tb_pipelined_if_fetch;

    logic        Clk = 1'b0;
    logic        Clr = 1'b1;
    logic        wpcir = 1'b1;
    logic [1:0]  Pcsource = 2'b00;
    logic [31:0] Bpc = '0, Rpc = '0, Jpc = '0;
    logic        Imem_Req, Imem_Ack;
    logic [31:0] Imem_Addr, Imem_Data, PC_plus4, IF_Inst;
    logic        IF_Valid;

    logic        req2, ack2, valid2;
    logic [31:0] addr2, data2, pc4_2, inst2;

    int   tests_run = 0;
    int   failed = 0;
    int   lat = 0;
    int   wait_cnt;
    logic use_rand = 1'b0;
    logic rand_ack = 1'b0;

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5677;
    endfunction

    // Memory model: acks after lat wait cycles (or randomly), reset with the fetch stage.
    assign Imem_Data = Imem_Req ? mem_word(Imem_Addr) : 32'hDEAD_BEEF;
    assign Imem_Ack  = Imem_Req && (use_rand ? rand_ack : (wait_cnt >= lat));
    always @(posedge Clk or posedge Clr) begin
        if (Clr) wait_cnt <= 0;
        else if (Imem_Req && Imem_Ack) wait_cnt <= 0;
        else if (Imem_Req) wait_cnt <= wait_cnt + 1;
    end

    assign ack2  = req2;
    assign data2 = mem_word(addr2);

    pipelined_if_fetch u_dut (
        .Clk(Clk), .Clr(Clr), .wpcir(wpcir), .Pcsource(Pcsource),
        .Bpc(Bpc), .Rpc(Rpc), .Jpc(Jpc),
        .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr), .Imem_Ack(Imem_Ack), .Imem_Data(Imem_Data),
        .PC_plus4(PC_plus4), .IF_Inst(IF_Inst), .IF_Valid(IF_Valid)
    );

    pipelined_if_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .Clk(Clk), .Clr(Clr), .wpcir(wpcir), .Pcsource(Pcsource),
        .Bpc(Bpc), .Rpc(Rpc), .Jpc(Jpc),
        .Imem_Req(req2), .Imem_Addr(addr2), .Imem_Ack(ack2), .Imem_Data(data2),
        .PC_plus4(pc4_2), .IF_Inst(inst2), .IF_Valid(valid2)
    );

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    // Pulse Clr between edges with sequential, advancing defaults; returns before the next edge.
    task automatic do_reset(input int l);
        @(negedge Clk);
        wpcir = 1'b1; Pcsource = 2'b00; Bpc = '0; Rpc = '0; Jpc = '0;
        use_rand = 1'b0; lat = l;
        Clr = 1'b1;
        #1;
        Clr = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #3;
        tests_run++; if (Imem_Req !== 1'b0) begin failed++; $display("FAIL reset_req: got %b want 0", Imem_Req); end
        tests_run++; if (IF_Valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b want 0", IF_Valid); end
        tests_run++; if (Imem_Addr !== 32'h0) begin failed++; $display("FAIL reset_addr: got %h want 0", Imem_Addr); end
        tests_run++; if (PC_plus4 !== 32'h4) begin failed++; $display("FAIL reset_pc4: got %h want 4", PC_plus4); end
        tests_run++; if (IF_Inst !== 32'hDEAD_BEEF) begin failed++; $display("FAIL reset_inst: got %h want deadbeef", IF_Inst); end
        tick();
        tests_run++; if (Imem_Addr !== 32'h0) begin failed++; $display("FAIL reset_hold_addr: got %h want 0", Imem_Addr); end
        Clr = 1'b0;
        #1;
        tests_run++; if (Imem_Req !== 1'b1) begin failed++; $display("FAIL first_req: got %b want 1", Imem_Req); end
    endtask

    task automatic test_zero_wait();
        do_reset(0);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            a = 32'(4 * i);
            tests_run++; if (Imem_Addr !== a) begin failed++; $display("FAIL zw_addr[%0d]: got %h want %h", i, Imem_Addr, a); end
            tests_run++; if (PC_plus4 !== a + 32'd4) begin failed++; $display("FAIL zw_pc4[%0d]: got %h want %h", i, PC_plus4, a + 32'd4); end
            tests_run++; if (IF_Valid !== 1'b1) begin failed++; $display("FAIL zw_valid[%0d]: got %b want 1", i, IF_Valid); end
            tests_run++; if (IF_Inst !== mem_word(a)) begin failed++; $display("FAIL zw_inst[%0d]: got %h want %h", i, IF_Inst, mem_word(a)); end
            tick();
        end
    endtask

    task automatic test_hold();
        do_reset(0);
        tick();
        tick();
        wpcir = 1'b0;
        #1;
        tests_run++; if (IF_Valid !== 1'b1 || IF_Inst !== mem_word(32'h8)) begin failed++; $display("FAIL hold_ack: got v=%b %h want v=1 %h", IF_Valid, IF_Inst, mem_word(32'h8)); end
        for (int k = 0; k < 3; k++) begin
            tick();
            tests_run++; if (Imem_Req !== 1'b0) begin failed++; $display("FAIL hold_req[%0d]: got %b want 0", k, Imem_Req); end
            tests_run++; if (IF_Inst !== mem_word(32'h8) || IF_Valid !== 1'b1) begin failed++; $display("FAIL hold_inst[%0d]: got v=%b %h want v=1 %h", k, IF_Valid, IF_Inst, mem_word(32'h8)); end
            tests_run++; if (PC_plus4 !== 32'hC) begin failed++; $display("FAIL hold_pc4[%0d]: got %h want c", k, PC_plus4); end
        end
        wpcir = 1'b1;
        tick();
        tests_run++; if (Imem_Addr !== 32'hC || Imem_Req !== 1'b1) begin failed++; $display("FAIL hold_release: got req=%b %h want req=1 c", Imem_Req, Imem_Addr); end
    endtask

    task automatic test_branch_drop();
        do_reset(0);
        repeat (4) tick();
        lat = 2; Pcsource = 2'b01; Bpc = 32'h40;
        #1;
        tests_run++; if (Imem_Addr !== 32'h10 || IF_Valid !== 1'b0) begin failed++; $display("FAIL br_issue: got v=%b %h want v=0 10", IF_Valid, Imem_Addr); end
        tick();
        Pcsource = 2'b00; Bpc = 32'h0;
        #1;
        tests_run++; if (Imem_Addr !== 32'h10 || Imem_Req !== 1'b1) begin failed++; $display("FAIL br_wait: got req=%b %h want req=1 10", Imem_Req, Imem_Addr); end
        tick();
        tests_run++; if (Imem_Ack !== 1'b1 || IF_Valid !== 1'b0 || Imem_Addr !== 32'h10) begin failed++; $display("FAIL br_drop_ack: got ack=%b v=%b %h want ack=1 v=0 10", Imem_Ack, IF_Valid, Imem_Addr); end
        tick();
        tests_run++; if (Imem_Addr !== 32'h40 || Imem_Req !== 1'b1) begin failed++; $display("FAIL br_target: got req=%b %h want req=1 40", Imem_Req, Imem_Addr); end
    endtask

    task automatic test_drop_latest();
        do_reset(3);
        Pcsource = 2'b11; Jpc = 32'h80;
        tick();
        Pcsource = 2'b10; Rpc = 32'h100; Jpc = 32'h0;
        #1;
        tests_run++; if (IF_Valid !== 1'b0 || Imem_Addr !== 32'h0) begin failed++; $display("FAIL dl_drop: got v=%b %h want v=0 0", IF_Valid, Imem_Addr); end
        tick();
        Pcsource = 2'b00; Rpc = 32'h0;
        tick();
        tests_run++; if (Imem_Ack !== 1'b1 || IF_Valid !== 1'b0 || Imem_Addr !== 32'h0) begin failed++; $display("FAIL dl_ack: got ack=%b v=%b %h want ack=1 v=0 0", Imem_Ack, IF_Valid, Imem_Addr); end
        tick();
        tests_run++; if (Imem_Addr !== 32'h100) begin failed++; $display("FAIL dl_latest: got %h want 100", Imem_Addr); end
    endtask

    task automatic test_clr_in_drop();
        do_reset(3);
        Pcsource = 2'b01; Bpc = 32'h40;
        tick();
        Pcsource = 2'b00;
        Clr = 1'b1;
        #1;
        tests_run++; if (Imem_Req !== 1'b0 || IF_Valid !== 1'b0) begin failed++; $display("FAIL clr_drop_now: got req=%b v=%b want 0 0", Imem_Req, IF_Valid); end
        Clr = 1'b0; lat = 0;
        #1;
        tests_run++; if (Imem_Addr !== 32'h0 || Imem_Req !== 1'b1 || IF_Valid !== 1'b1) begin failed++; $display("FAIL clr_drop_after: got req=%b v=%b %h want 1 1 0", Imem_Req, IF_Valid, Imem_Addr); end
        tick();
        tests_run++; if (Imem_Addr !== 32'h4) begin failed++; $display("FAIL clr_drop_next: got %h want 4", Imem_Addr); end
    endtask

    task automatic test_wrap();
        do_reset(0);
        tests_run++; if (addr2 !== 32'hFFFF_FFFC || pc4_2 !== 32'h0 || valid2 !== 1'b1) begin failed++; $display("FAIL wrap_first: got %h pc4=%h v=%b want fffffffc 0 1", addr2, pc4_2, valid2); end
        tick();
        tests_run++; if (addr2 !== 32'h0 || pc4_2 !== 32'h4) begin failed++; $display("FAIL wrap_next: got %h pc4=%h want 0 4", addr2, pc4_2); end
    endtask

    // The captured stream must follow program order: each instruction IF/ID takes is
    // the successor of the previous one, or the latest redirect target since it.
    task automatic test_random();
        logic [31:0] exp_addr, tgt, prev_addr;
        logic        prev_out;
        int          captured, bad;
        do_reset(0);
        use_rand = 1'b1;
        exp_addr = 32'h0; prev_out = 1'b0; prev_addr = '0; captured = 0; bad = 0;
        for (int n = 0; n < 2000; n++) begin
            wpcir    = ($urandom_range(3) != 0);
            Pcsource = ($urandom_range(5) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            Bpc      = $urandom & 32'hFFFF_FFFC;
            Rpc      = $urandom & 32'hFFFF_FFFC;
            Jpc      = $urandom & 32'hFFFF_FFFC;
            rand_ack = 1'($urandom_range(1));
            #1;
            tgt = (Pcsource == 2'b01) ? Bpc : (Pcsource == 2'b10) ? Rpc : Jpc;
            if (prev_out && bad < 10) begin
                tests_run++;
                if (Imem_Req !== 1'b1 || Imem_Addr !== prev_addr) begin failed++; bad++; $display("FAIL rnd_bus_stable[%0d]: got req=%b %h want req=1 %h", n, Imem_Req, Imem_Addr, prev_addr); end
            end
            if (Imem_Req === 1'b0 && bad < 10) begin
                tests_run++;
                if (IF_Valid !== 1'b1) begin failed++; bad++; $display("FAIL rnd_idle_valid[%0d]: got %b want 1", n, IF_Valid); end
            end
            if (wpcir) begin
                if (IF_Valid === 1'b1) begin
                    captured++;
                    if (bad < 10) begin
                        tests_run++;
                        if (IF_Inst !== mem_word(exp_addr) || PC_plus4 !== exp_addr + 32'd4) begin
                            failed++; bad++;
                            $display("FAIL rnd_stream[%0d]: got %h pc4=%h want %h pc4=%h", n, IF_Inst, PC_plus4, mem_word(exp_addr), exp_addr + 32'd4);
                        end
                    end
                    exp_addr = (Pcsource != 2'b00) ? tgt : exp_addr + 32'd4;
                end else if (Pcsource != 2'b00) begin
                    exp_addr = tgt;
                end
            end
            prev_out  = Imem_Req && !Imem_Ack;
            prev_addr = Imem_Addr;
            tick();
        end
        tests_run++;
        if (captured < 100) begin failed++; $display("FAIL rnd_progress: got %0d captured want >= 100", captured); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_hold();
        test_branch_drop();
        test_drop_latest();
        test_clr_in_drop();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
